// File: rtl/decode_out_queue.sv
// DEPTH-entry FIFO on the LC3 decode_out bus between decode and execute.
// Valid/ready on both sides; synchronous flush drops all queued bundles.
module decode_out_queue #(
    parameter int DEPTH    = 4,
    parameter int WORD_W   = 16,
    parameter int E_CTRL_W = 6,
    parameter int W_CTRL_W = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W_CTRL_W-1:0]     in_w_control,
    input  logic                    in_mem_control,
    input  logic [E_CTRL_W-1:0]     in_e_control,
    input  logic [WORD_W-1:0]       in_ir,
    input  logic [WORD_W-1:0]       in_npc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W_CTRL_W-1:0]     out_w_control,
    output logic                    out_mem_control,
    output logic [E_CTRL_W-1:0]     out_e_control,
    output logic [WORD_W-1:0]       out_ir,
    output logic [WORD_W-1:0]       out_npc,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [W_CTRL_W-1:0] w_control;
        logic                mem_control;
        logic [E_CTRL_W-1:0] e_control;
        logic [WORD_W-1:0]   ir;
        logic [WORD_W-1:0]   npc;
    } bundle_t;

    bundle_t         r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_ready_en;

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_in_ready;
    bundle_t         w_in_bundle;
    bundle_t         w_head;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_in_ready = r_ready_en & ~w_full & ~flush;
    assign w_push     = in_valid & w_in_ready;
    assign w_pop      = ~w_empty & out_ready;

    assign w_in_bundle = '{
        w_control:   in_w_control,
        mem_control: in_mem_control,
        e_control:   in_e_control,
        ir:          in_ir,
        npc:         in_npc
    };

    // Stale storage stays hidden: the head is masked whenever the queue is empty.
    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

    assign in_ready        = w_in_ready;
    assign out_valid       = ~w_empty;
    assign out_w_control   = w_head.w_control;
    assign out_mem_control = w_head.mem_control;
    assign out_e_control   = w_head.e_control;
    assign out_ir          = w_head.ir;
    assign out_npc         = w_head.npc;
    assign count           = r_count;
    assign full            = w_full;
    assign empty           = w_empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_bundle;
        end
    end

`ifndef SYNTHESIS
    a_count_bound: assert property (
        @(posedge clock) disable iff (!reset) r_count <= CW'(DEPTH));
    a_no_underflow: assert property (
        @(posedge clock) disable iff (!reset) !(w_pop && w_empty));
`endif

endmodule

// File: tb/tb_decode_out_queue.sv
// Bench for decode_out_queue: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_decode_out_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_w_control = '0;
    logic        in_mem_control = 1'b0;
    logic [5:0]  in_e_control = '0;
    logic [15:0] in_ir = '0;
    logic [15:0] in_npc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_w_control;
    logic        out_mem_control;
    logic [5:0]  out_e_control;
    logic [15:0] out_ir;
    logic [15:0] out_npc;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    decode_out_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_w_control(in_w_control), .in_mem_control(in_mem_control),
        .in_e_control(in_e_control), .in_ir(in_ir), .in_npc(in_npc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_w_control(out_w_control), .out_mem_control(out_mem_control),
        .out_e_control(out_e_control), .out_ir(out_ir), .out_npc(out_npc),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a plain queue of packed bundles
    // {w_control[40:39], mem[38], e_control[37:32], ir[31:16], npc[15:0]}.
    logic [40:0] m_q[$];
    bit          m_ready_en = 1'b0;
    int          n_out_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [40:0] mk(input logic [1:0] w, input logic m,
                                       input logic [5:0] e,
                                       input logic [15:0] ir,
                                       input logic [15:0] npc);
        return {w, m, e, ir, npc};
    endfunction

    task automatic step(input string tag, input logic rst, input logic v,
                        input logic r, input logic f, input logic [40:0] b);
        logic [40:0] head;
        bit          exp_ready;
        bit          exp_valid;
        bit          do_push;
        bit          do_pop;
        @(negedge clock);
        reset = rst;
        in_valid = v;
        out_ready = r;
        flush = f;
        {in_w_control, in_mem_control, in_e_control, in_ir, in_npc} = b;
        if (!rst) begin
            m_q.delete();
            m_ready_en = 1'b0;
        end
        #1;
        exp_ready = m_ready_en && (m_q.size() < DEPTH) && !f;
        exp_valid = (m_q.size() != 0);
        head = exp_valid ? m_q[0] : '0;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_ready));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
        chk({tag, ".count"}, 64'(count), 64'(m_q.size()));
        chk({tag, ".full"}, 64'(full), 64'(m_q.size() == DEPTH));
        chk({tag, ".empty"}, 64'(empty), 64'(m_q.size() == 0));
        chk({tag, ".payload"},
            64'({out_w_control, out_mem_control, out_e_control,
                 out_ir, out_npc}), 64'(head));
        do_push = v && exp_ready;
        do_pop = exp_valid && r;
        if (do_pop) n_out_seen++;
        @(posedge clock);
        if (rst) begin
            if (f) begin
                m_q.delete();
            end else begin
                if (do_pop) void'(m_q.pop_front());
                if (do_push) m_q.push_back(b);
            end
            m_ready_en = 1'b1;
        end
    endtask

    initial begin
        logic [40:0] b;
        logic [40:0] idle;
        idle = '0;

        // Reset held for three clocks, then release.
        repeat (3) step("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, idle);
        step("rst_rel1", 1'b1, 1'b0, 1'b0, 1'b0, idle);
        step("rst_rel2", 1'b1, 1'b0, 1'b0, 1'b0, idle);

        // Single push and pop.
        b = mk(2'd1, 1'b0, 6'h2A, 16'h1234, 16'h3001);
        step("single_push", 1'b1, 1'b1, 1'b0, 1'b0, b);
        step("single_pop", 1'b1, 1'b0, 1'b1, 1'b0, idle);
        step("single_after", 1'b1, 1'b0, 1'b0, 1'b0, idle);

        // Fill to DEPTH, offer a fifth, then drain in order.
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = mk(2'd2, 1'b1, 6'(i), 16'hA000 + 16'(i), 16'h3000 + 16'(i));
            step("fill", 1'b1, 1'b1, 1'b0, 1'b0, b);
        end
        chk("fill.full", 64'(full), 64'd1);
        for (int i = 0; i < DEPTH + 1; i++) begin
            step("drain", 1'b1, 1'b0, 1'b1, 1'b0, idle);
        end

        // Streaming: simultaneous push and pop every cycle.
        for (int i = 0; i < 20; i++) begin
            b = mk(2'(i), 1'(i), 6'(i), 16'hC000 + 16'(i), 16'(i));
            step("stream", 1'b1, 1'b1, 1'b1, 1'b0, b);
        end
        step("stream_tail", 1'b1, 1'b0, 1'b1, 1'b0, idle);

        // Flush with three entries queued and a push offered.
        for (int i = 0; i < 3; i++) begin
            b = mk(2'd3, 1'b0, 6'h11, 16'hD000 + 16'(i), 16'h0);
            step("pre_flush", 1'b1, 1'b1, 1'b0, 1'b0, b);
        end
        b = mk(2'd0, 1'b1, 6'h3F, 16'hBEEF, 16'h4000);
        step("flush", 1'b1, 1'b1, 1'b0, 1'b1, b);
        step("post_flush", 1'b1, 1'b0, 1'b1, 1'b0, idle);

        // Reset asserted between edges with two entries queued.
        for (int i = 0; i < 2; i++) begin
            b = mk(2'd1, 1'b1, 6'h05, 16'hE000 + 16'(i), 16'h0);
            step("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0, b);
        end
        step("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, idle);
        step("rst_rel_a", 1'b1, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 16'hF00D, 0));
        step("rst_rel_b", 1'b1, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 16'hF00E, 0));
        step("rst_rel_c", 1'b1, 1'b0, 1'b1, 1'b0, idle);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            b = 41'({$urandom, $urandom});
            step("rand",
                 ($urandom_range(0, 149) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0),
                 b);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
